// File: rtl/spi_reg_ctrl.sv
// Register-bank controller behind the SPI slave: SPI/local arbitration, fast commands, status byte.
// SPI side is zero-latency and never stalls; local side waits on SPI writes and on bank clear.
module spi_reg_ctrl #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [REG_W-1:0]  spi_wdata,
  input  logic              spi_wr,
  output logic [REG_W-1:0]  spi_rdata,
  input  logic [5:0]        fastcmd,
  input  logic              fastcmd_vld,
  output logic [7:0]        status,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [REG_W-1:0]  loc_wdata,
  output logic              loc_gnt,
  output logic [REG_W-1:0]  loc_rdata,
  output logic              loc_rvld,
  output logic              evt,
  output logic [5:0]        evt_code
);

  localparam int NREGS = 1 << ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [5:0] FC_CLEAR  = 6'h00;
  localparam logic [5:0] FC_LOCK   = 6'h01;
  localparam logic [5:0] FC_UNLOCK = 6'h02;
  localparam logic [5:0] FC_ERRCLR = 6'h3F;

  logic [REG_W-1:0]  bank_q [NREGS];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [REG_W-1:0]  loc_rdata_q, loc_rdata_d;
  logic              loc_rvld_q, loc_rvld_d;
  logic              evt_q, evt_d;
  logic [5:0]        evt_code_q, evt_code_d;

  logic              idle;
  logic              spi_wr_ok;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [REG_W-1:0]  bank_wdat;

  assign idle      = (state_q == ST_IDLE);
  assign spi_wr_ok = spi_wr && idle && !locked_q;
  assign loc_gnt   = loc_req && idle && !spi_wr;

  assign spi_rdata = bank_q[spi_addr];
  assign loc_rdata = loc_rdata_q;
  assign loc_rvld  = loc_rvld_q;
  assign evt       = evt_q;
  assign evt_code  = evt_code_q;
  assign status    = {!idle, locked_q, err_q, 5'b0};

  // Single bank write port: clear, SPI and local grants are mutually exclusive by construction.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = '0;
    bank_wdat  = '0;
    if (!idle) begin
      bank_we    = 1'b1;
      bank_waddr = clr_cnt_q;
    end else if (spi_wr_ok) begin
      bank_we    = 1'b1;
      bank_waddr = spi_addr;
      bank_wdat  = spi_wdata;
    end else if (loc_gnt && loc_we) begin
      bank_we    = 1'b1;
      bank_waddr = loc_addr;
      bank_wdat  = loc_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    locked_d    = locked_q;
    err_d       = err_q;
    loc_rdata_d = loc_rdata_q;
    loc_rvld_d  = 1'b0;
    evt_d       = 1'b0;
    evt_code_d  = evt_code_q;

    if (idle) begin
      if (fastcmd_vld && fastcmd == FC_CLEAR) begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    end else begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_IDLE;
      end
    end

    if (fastcmd_vld && fastcmd == FC_LOCK) begin
      locked_d = 1'b1;
    end else if (fastcmd_vld && fastcmd == FC_UNLOCK) begin
      locked_d = 1'b0;
    end

    // A dropped write outranks an error clear in the same cycle.
    if (spi_wr && (locked_q || !idle)) begin
      err_d = 1'b1;
    end else if (fastcmd_vld && fastcmd == FC_ERRCLR) begin
      err_d = 1'b0;
    end

    if (fastcmd_vld && fastcmd != FC_CLEAR && fastcmd != FC_LOCK &&
        fastcmd != FC_UNLOCK && fastcmd != FC_ERRCLR) begin
      evt_d      = 1'b1;
      evt_code_d = fastcmd;
    end

    if (loc_gnt && !loc_we) begin
      loc_rvld_d  = 1'b1;
      loc_rdata_d = bank_q[loc_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      loc_rdata_q <= '0;
      loc_rvld_q  <= 1'b0;
      evt_q       <= 1'b0;
      evt_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      loc_rdata_q <= loc_rdata_d;
      loc_rvld_q  <= loc_rvld_d;
      evt_q       <= evt_d;
      evt_code_q  <= evt_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bank_we) begin
      bank_q[bank_waddr] <= bank_wdat;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: table of SPI/fast-command vectors plus clear/collision/reset sequences.
module tb_spi_reg_ctrl;

  localparam int ADDR_W = 6;
  localparam int REG_W  = 16;
  localparam int NREGS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] spi_addr;
  logic [REG_W-1:0]  spi_wdata;
  logic              spi_wr;
  logic [REG_W-1:0]  spi_rdata;
  logic [5:0]        fastcmd;
  logic              fastcmd_vld;
  logic [7:0]        status;
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [REG_W-1:0]  loc_wdata;
  logic              loc_gnt;
  logic [REG_W-1:0]  loc_rdata;
  logic              loc_rvld;
  logic              evt;
  logic [5:0]        evt_code;

  int n_cmp = 0;
  int n_err = 0;

  logic [REG_W-1:0] rd_q[$];

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wr(spi_wr), .spi_rdata(spi_rdata),
    .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld), .status(status),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvld(loc_rvld),
    .evt(evt), .evt_code(evt_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every local read data pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (loc_rvld) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL loc_rvld_unexpected: got rdata %h, expected no pulse", loc_rdata);
      end else begin
        chk("loc_rdata", 32'(loc_rdata), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d);
    spi_addr = a; spi_wdata = d; spi_wr = 1'b1;
    step();
    spi_wr = 1'b0;
  endtask

  task automatic fcmd(input logic [5:0] c);
    fastcmd = c; fastcmd_vld = 1'b1;
    step();
    fastcmd_vld = 1'b0;
  endtask

  typedef struct {
    bit               is_fc;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0] data;
    logic [5:0]       code;
    logic [7:0]       exp_status;
    logic [REG_W-1:0] exp_rd;
    bit               exp_evt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int busy_cnt;
    int nz;

    tbl[0] = '{is_fc: 0, addr: 6'd5, data: 16'hA55A, code: 6'h00, exp_status: 8'h00, exp_rd: 16'hA55A, exp_evt: 0};
    tbl[1] = '{is_fc: 1, addr: 6'd7, data: 16'h0000, code: 6'h01, exp_status: 8'h40, exp_rd: 16'h0000, exp_evt: 0};
    tbl[2] = '{is_fc: 0, addr: 6'd7, data: 16'hFFFF, code: 6'h00, exp_status: 8'h60, exp_rd: 16'h0000, exp_evt: 0};
    tbl[3] = '{is_fc: 1, addr: 6'd7, data: 16'h0000, code: 6'h3F, exp_status: 8'h40, exp_rd: 16'h0000, exp_evt: 0};
    tbl[4] = '{is_fc: 1, addr: 6'd7, data: 16'h0000, code: 6'h02, exp_status: 8'h00, exp_rd: 16'h0000, exp_evt: 0};
    tbl[5] = '{is_fc: 0, addr: 6'd7, data: 16'hFFFF, code: 6'h00, exp_status: 8'h00, exp_rd: 16'hFFFF, exp_evt: 0};
    tbl[6] = '{is_fc: 1, addr: 6'd5, data: 16'h0000, code: 6'h15, exp_status: 8'h00, exp_rd: 16'hA55A, exp_evt: 1};

    rst = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wr = 1'b0;
    fastcmd = '0; fastcmd_vld = 1'b0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_spi_rdata", 32'(spi_rdata), 32'h0);
    chk("rst_loc_rvld", 32'(loc_rvld), 32'h0);
    chk("rst_loc_rdata", 32'(loc_rdata), 32'h0);
    chk("rst_evt", 32'(evt), 32'h0);
    chk("rst_evt_code", 32'(evt_code), 32'h0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_fc) fcmd(tbl[i].code);
      else spi_write(tbl[i].addr, tbl[i].data);
      spi_addr = tbl[i].addr;
      #1;
      chk($sformatf("vec%0d_status", i), 32'(status), 32'(tbl[i].exp_status));
      chk($sformatf("vec%0d_rdata", i), 32'(spi_rdata), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_evt", i), 32'(evt), 32'(tbl[i].exp_evt));
    end
    chk("evt_code", 32'(evt_code), 32'h15);
    step();
    chk("evt_single_pulse", 32'(evt), 32'h0);

    // Local read of addr 5: grant in the request cycle, data the cycle after.
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 6'd5;
    #1;
    chk("loc_gnt_idle", 32'(loc_gnt), 32'h1);
    rd_q.push_back(16'hA55A);
    step();
    loc_req = 1'b0;
    chk("loc_rvld_next", 32'(loc_rvld), 32'h1);
    step();

    // Collision on addr 3: local held off one cycle, its value lands last.
    spi_addr = 6'd3; spi_wdata = 16'h1111; spi_wr = 1'b1;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 6'd3; loc_wdata = 16'h2222;
    #1;
    chk("coll_gnt_low", 32'(loc_gnt), 32'h0);
    step();
    spi_wr = 1'b0;
    #1;
    chk("coll_gnt_high", 32'(loc_gnt), 32'h1);
    step();
    loc_req = 1'b0; loc_we = 1'b0;
    #1;
    chk("coll_final", 32'(spi_rdata), 32'h2222);

    for (int i = 0; i < NREGS; i++) spi_write(ADDR_W'(i), REG_W'(i * 257 + 1));
    spi_addr = 6'd63;
    #1;
    chk("fill_last", 32'(spi_rdata), 32'(16'(63 * 257 + 1)));

    // Bank clear with a local read waiting, a repeated CLEAR and a dropped SPI write inside it.
    fcmd(6'h00);
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 6'd40;
    #1;
    busy_cnt = 0;
    while (status[7] && busy_cnt < 200) begin
      busy_cnt++;
      if (loc_gnt) begin
        n_cmp++; n_err++;
        $display("FAIL gnt_during_clear: got gnt=1 at busy cycle %0d, expected 0", busy_cnt);
      end
      if (busy_cnt == 10) begin
        fastcmd = 6'h00; fastcmd_vld = 1'b1;
      end
      if (busy_cnt == 20) begin
        spi_addr = 6'd9; spi_wdata = 16'h1234; spi_wr = 1'b1;
      end
      step();
      fastcmd_vld = 1'b0; spi_wr = 1'b0;
      #1;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd64);
    chk("gnt_after_clear", 32'(loc_gnt), 32'h1);
    chk("status_after_clear", 32'(status), 32'h20);
    rd_q.push_back(16'h0000);
    step();
    loc_req = 1'b0;
    nz = 0;
    for (int i = 0; i < NREGS; i++) begin
      spi_addr = ADDR_W'(i);
      #1;
      if (spi_rdata !== '0) nz++;
    end
    chk("bank_cleared_nonzero", 32'(nz), 32'd0);
    fcmd(6'h3F);
    chk("errclr", 32'(status), 32'h00);

    // Reset in the middle of a clear.
    spi_write(6'd4, 16'hBEEF);
    spi_write(6'd60, 16'h7777);
    fcmd(6'h00);
    repeat (5) step();
    spi_addr = 6'd60;
    #1;
    chk("pre_rst_untouched", 32'(spi_rdata), 32'h7777);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midclr_rst_status", 32'(status), 32'h00);
    chk("midclr_rst_evt_code", 32'(evt_code), 32'h0);
    nz = 0;
    for (int i = 0; i < NREGS; i++) begin
      spi_addr = ADDR_W'(i);
      #1;
      if (spi_rdata !== '0) nz++;
    end
    chk("midclr_rst_bank_nonzero", 32'(nz), 32'd0);
    step();
    chk("midclr_rst_stays_idle", 32'(status), 32'h00);

    step();
    chk("scoreboard_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Register-bank controller that sits behind the SPI register slave and owns a 2**ADDR_W x REG_W register bank.
- Shares the bank between the SPI port (host writes/reads) and a local on-chip requester port.
- Decodes SPI fast commands: sequenced bank clear, write lock/unlock, error clear.
- Produces the 8-bit status byte that the SPI slave returns at the start of every transaction.

Parameters:
ADDR_W, 6, register address width; bank depth NREGS = 2**ADDR_W
REG_W, 16, register width in bits (multiple of 8, 8..64)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
spi_addr  input  ADDR_W  register address from SPI slave
spi_wdata  input  REG_W  write data from SPI slave
spi_wr  input  1  one-cycle SPI write strobe
spi_rdata  output  REG_W  read data to SPI slave, combinational bank[spi_addr]
fastcmd  input  6  fast command code
fastcmd_vld  input  1  one-cycle fast command strobe
status  output  8  {busy, locked, err, 5'b0}
loc_req  input  1  local access request, held until loc_gnt
loc_we  input  1  local write enable, qualified by loc_req
loc_addr  input  ADDR_W  local address
loc_wdata  input  REG_W  local write data
loc_gnt  output  1  one-cycle grant; the access is performed in this cycle
loc_rdata  output  REG_W  local read data, registered
loc_rvld  output  1  one-cycle pulse, cycle after a granted read
evt  output  1  one-cycle pulse for an unrecognised fast command
evt_code  output  6  code of the last unrecognised fast command

Behaviour:
Reset (rst=1 at posedge clk):
- All bank entries 0; state IDLE.
- locked=0, err=0, clr_cnt=0.
- loc_gnt=0, loc_rvld=0, loc_rdata=0, evt=0, evt_code=0.
- Reset takes priority over every event in the same cycle, including mid-CLEAR.

FSM, two states:
- IDLE: normal arbitration.
- CLEAR: walks clr_cnt from 0 to NREGS-1, writing 0 to bank[clr_cnt] each cycle. Return to IDLE in the cycle after clr_cnt = NREGS-1 is written. CLEAR lasts exactly NREGS cycles.
- busy = (state == CLEAR).

SPI write (spi_wr=1):
- IDLE and not locked: bank[spi_addr] <= spi_wdata at this edge.
- locked, or state CLEAR: write dropped; err <= 1 (sticky).
- SPI never stalls and always has priority over the local port.

SPI read:
- spi_rdata = bank[spi_addr], combinational, no latency.
- During CLEAR it reflects partially cleared contents.

Local port:
- loc_gnt = loc_req && state==IDLE && !spi_wr (combinational, one cycle).
- Granted write: bank[loc_addr] <= loc_wdata at the grant edge. The lock does not apply to the local port.
- Granted read: loc_rdata <= bank[loc_addr] at the grant edge (pre-write value); loc_rvld=1 the next cycle.
- Requester deasserts loc_req or presents the next access after seeing loc_gnt.
- Back-to-back grants are allowed.
- Collision (spi_wr and loc_req in the same cycle, any address): local is held off one cycle. If it is then granted to the same address, the local value is final.
- Worst-case local latency in IDLE is 2 cycles, because SPI strobes are separated by many clk cycles.

Fast commands (fastcmd_vld=1):
- 6'h00 CLEAR: IDLE -> CLEAR, clr_cnt <= 0. Ignored while already in CLEAR.
- 6'h01 LOCK: locked <= 1.
- 6'h02 UNLOCK: locked <= 0.
- 6'h3F ERRCLR: err <= 0. If spi_wr sets err in the same cycle, set wins.
- Any other code: evt=1 next cycle, evt_code <= fastcmd.
- LOCK, UNLOCK, ERRCLR and events are processed in both states.

Status:
- status is registered state only; bits [4:0] = 0.

Test Plan:
- Reset, then SPI write addr 5 = 16'hA55A -> spi_rdata at addr 5 = 16'hA55A; local read of addr 5 -> loc_gnt in the request cycle, loc_rvld + loc_rdata=16'hA55A one cycle later.
- spi_wr (addr 3, 16'h1111) and local write (addr 3, 16'h2222) in the same cycle -> loc_gnt low that cycle, high the next; final bank[3]=16'h2222.
- Fastcmd 6'h01, then SPI write addr 7 = 16'hFFFF -> bank[7] unchanged, status=8'b0110_0000. Fastcmd 6'h3F -> status=8'b0100_0000. Fastcmd 6'h02, then the write succeeds.
- Fill the bank, then fastcmd 6'h00 -> busy for exactly 64 cycles (ADDR_W=6). loc_req is not granted until busy falls. A second 6'h00 mid-clear does not extend it. All registers read 0 afterwards.
- spi_wr during CLEAR -> write dropped, err=1. rst asserted mid-CLEAR -> state IDLE, status=0, bank all 0 the next cycle.
- Fastcmd 6'h15 -> evt pulse one cycle, evt_code=6'h15; bank and status unchanged.
